// File: rtl/instr_tag_ram_ctrl.sv
// Tag-RAM port sequencer: serializes fetch lookups, snoop-invalidates and line-fill tag
// writes onto a single-port {state, tag} array with a one-cycle registered read.
//
// state   | meaning
// IDLE    | arbitrating; the granted requester sees ready
// LK_RD   | lookup read address presented to the array
// LK_CMP  | lookup read data returned, tag/state compare
// SN_RD   | snoop read address presented to the array
// SN_CMP  | snoop read data returned, tag/state compare
// SN_WR   | snoop hit: entry rewritten as invalid
// FILL_WR | fill tag written as clean
module instr_tag_ram_ctrl #(
    parameter int SET_WIDTH    = 4,
    parameter int STATE_WIDTH  = 2,
    parameter int TAG_WIDTH    = 22,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             lk_valid_i,
    output logic                             lk_ready_o,
    input  logic [31:0]                      lk_addr_i,
    output logic                             lk_resp_valid_o,
    output logic                             lk_hit_o,
    output logic [STATE_WIDTH-1:0]           lk_state_o,
    input  logic                             sn_valid_i,
    output logic                             sn_ready_o,
    input  logic [31:0]                      sn_addr_i,
    output logic                             sn_resp_valid_o,
    output logic                             sn_hit_o,
    input  logic                             fill_valid_i,
    output logic                             fill_ready_o,
    input  logic [31:0]                      fill_addr_i,
    output logic                             ram_w_en_o,
    output logic [STATE_WIDTH+TAG_WIDTH-1:0] ram_w_state_tag_o,
    output logic [SET_WIDTH-1:0]             ram_rw_addr_o,
    input  logic [STATE_WIDTH+TAG_WIDTH-1:0] ram_r_state_tag_i
);

    localparam logic [STATE_WIDTH-1:0] ST_I       = STATE_WIDTH'(2'b10);
    localparam logic [STATE_WIDTH-1:0] ST_C       = STATE_WIDTH'(2'b01);
    localparam logic [3:0]             STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LK_RD   = 3'd1,
        LK_CMP  = 3'd2,
        SN_RD   = 3'd3,
        SN_CMP  = 3'd4,
        SN_WR   = 3'd5,
        FILL_WR = 3'd6
    } state_e;

    state_e                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [SET_WIDTH-1:0]   set_q;
    logic [3:0]             starve_q;
    logic                   lk_resp_valid_q;
    logic                   lk_hit_q;
    logic [STATE_WIDTH-1:0] lk_state_q;
    logic                   sn_resp_valid_q;
    logic                   sn_hit_q;

    logic                   is_idle;
    logic                   starved;
    logic                   lk_gnt;
    logic                   sn_gnt;
    logic                   fill_gnt;
    logic                   any_gnt;
    logic [31:0]            acc_addr;
    logic [TAG_WIDTH-1:0]   rd_tag;
    logic [STATE_WIDTH-1:0] rd_state;
    logic                   hit;
    logic                   unused_addr_lsbs;

    assign is_idle  = (state_q == IDLE);
    assign starved  = (starve_q == STARVE_MAX);

    // A starved lookup pre-empts the fixed fill > snoop > lookup order.
    assign lk_gnt   = is_idle && lk_valid_i && (starved || (!fill_valid_i && !sn_valid_i));
    assign fill_gnt = is_idle && fill_valid_i && !(lk_valid_i && starved);
    assign sn_gnt   = is_idle && sn_valid_i && !fill_valid_i && !(lk_valid_i && starved);
    assign any_gnt  = lk_gnt || sn_gnt || fill_gnt;

    assign acc_addr = fill_gnt ? fill_addr_i : (sn_gnt ? sn_addr_i : lk_addr_i);
    assign unused_addr_lsbs = ^acc_addr[5:0];

    assign rd_tag   = ram_r_state_tag_i[TAG_WIDTH-1:0];
    assign rd_state = ram_r_state_tag_i[STATE_WIDTH+TAG_WIDTH-1:TAG_WIDTH];
    assign hit      = (rd_tag == tag_q) && (rd_state != ST_I);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fill_gnt) begin
                    state_d = FILL_WR;
                end else if (sn_gnt) begin
                    state_d = SN_RD;
                end else if (lk_gnt) begin
                    state_d = LK_RD;
                end
            end
            LK_RD:   state_d = LK_CMP;
            LK_CMP:  state_d = IDLE;
            SN_RD:   state_d = SN_CMP;
            SN_CMP:  state_d = hit ? SN_WR : IDLE;
            SN_WR:   state_d = IDLE;
            FILL_WR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Readies and the write strobe are gated by reset so nothing is accepted or written
    // in a reset cycle.
    always_comb begin
        lk_ready_o        = lk_gnt && !rst_i;
        sn_ready_o        = sn_gnt && !rst_i;
        fill_ready_o      = fill_gnt && !rst_i;
        ram_w_en_o        = 1'b0;
        ram_w_state_tag_o = '0;
        ram_rw_addr_o     = is_idle ? '0 : set_q;
        case (state_q)
            SN_WR: begin
                ram_w_en_o        = !rst_i;
                ram_w_state_tag_o = {ST_I, tag_q};
            end
            FILL_WR: begin
                ram_w_en_o        = !rst_i;
                ram_w_state_tag_o = {ST_C, tag_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q           <= '0;
            set_q           <= '0;
            starve_q        <= '0;
            lk_resp_valid_q <= 1'b0;
            lk_hit_q        <= 1'b0;
            lk_state_q      <= ST_I;
            sn_resp_valid_q <= 1'b0;
            sn_hit_q        <= 1'b0;
        end else begin
            lk_resp_valid_q <= (state_q == LK_CMP);
            sn_resp_valid_q <= (state_q == SN_CMP);
            if (any_gnt) begin
                tag_q <= acc_addr[31:32-TAG_WIDTH];
                set_q <= acc_addr[SET_WIDTH+5:6];
            end
            if (state_q == LK_CMP) begin
                lk_hit_q   <= hit;
                lk_state_q <= rd_state;
            end
            if (state_q == SN_CMP) begin
                sn_hit_q <= hit;
            end
            if (lk_gnt) begin
                starve_q <= '0;
            end else if (lk_valid_i && (fill_gnt || sn_gnt) && !starved) begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end

    assign lk_resp_valid_o = lk_resp_valid_q;
    assign lk_hit_o        = lk_hit_q;
    assign lk_state_o      = lk_state_q;
    assign sn_resp_valid_o = sn_resp_valid_q;
    assign sn_hit_o        = sn_hit_q;

endmodule

// File: tb/tb_instr_tag_ram_ctrl.sv
// Bench for instr_tag_ram_ctrl: directed scenarios plus random traffic, checked by a
// transaction-level shadow of the tag array feeding response/write scoreboards.
module tb_instr_tag_ram_ctrl;
    localparam int LIM = 2;
    localparam int DW  = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_clr = 1'b1;
    logic lk_valid, lk_ready, lk_resp_valid, lk_hit;
    logic [31:0] lk_addr;
    logic [1:0] lk_state;
    logic sn_valid, sn_ready, sn_resp_valid, sn_hit;
    logic [31:0] sn_addr;
    logic fill_valid, fill_ready;
    logic [31:0] fill_addr;
    logic ram_w_en;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [3:0] ram_addr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_tag_ram_ctrl #(.SET_WIDTH(4), .STATE_WIDTH(2), .TAG_WIDTH(22), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_i(rst),
        .lk_valid_i(lk_valid), .lk_ready_o(lk_ready), .lk_addr_i(lk_addr),
        .lk_resp_valid_o(lk_resp_valid), .lk_hit_o(lk_hit), .lk_state_o(lk_state),
        .sn_valid_i(sn_valid), .sn_ready_o(sn_ready), .sn_addr_i(sn_addr),
        .sn_resp_valid_o(sn_resp_valid), .sn_hit_o(sn_hit),
        .fill_valid_i(fill_valid), .fill_ready_o(fill_ready), .fill_addr_i(fill_addr),
        .ram_w_en_o(ram_w_en), .ram_w_state_tag_o(ram_wdata),
        .ram_rw_addr_o(ram_addr), .ram_r_state_tag_i(ram_rdata)
    );

    // Single-port array with registered read.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= {2'b10, 22'd0};
            ram_rdata <= {2'b10, 22'd0};
        end else begin
            if (ram_w_en) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct { int cyc; bit hit; logic [1:0] st; } lk_exp_t;
    typedef struct { int cyc; bit hit; } sn_exp_t;
    typedef struct { int cyc; logic [3:0] set; logic [23:0] data; } wr_exp_t;

    lk_exp_t lkq[$];
    sn_exp_t snq[$];
    wr_exp_t wq[$];

    logic [23:0] shadow [16];
    int busy = 0;
    int scnt = 0;
    bit pend = 0;
    logic [3:0] pend_set;
    logic [23:0] pend_data;

    // Reference model and monitor: owns arbitration expectations and the shadow array.
    always @(negedge clk) begin
        logic [2:0] rdy, expg;
        logic [21:0] t;
        logic [3:0] s;
        logic [23:0] e;
        bit h;
        lk_exp_t le;
        sn_exp_t se;
        wr_exp_t we;
        if (ram_clr) for (int i = 0; i < 16; i++) shadow[i] = {2'b10, 22'd0};
        rdy = {fill_ready, sn_ready, lk_ready};
        if (rst) begin
            check_eq("ready_in_reset", rdy, 0);
            check_eq("wen_in_reset", ram_w_en, 0);
            lkq.delete(); snq.delete(); wq.delete();
            busy = 0; pend = 0; scnt = 0;
        end else begin
            if (lk_resp_valid) begin
                if (lkq.size() == 0) check_eq("lk_resp_unexpected", lk_resp_valid, 0);
                else begin
                    le = lkq.pop_front();
                    check_eq("lk_resp_cycle", cyc, le.cyc);
                    check_eq("lk_hit", lk_hit, le.hit);
                    check_eq("lk_state", lk_state, le.st);
                end
            end
            if (sn_resp_valid) begin
                if (snq.size() == 0) check_eq("sn_resp_unexpected", sn_resp_valid, 0);
                else begin
                    se = snq.pop_front();
                    check_eq("sn_resp_cycle", cyc, se.cyc);
                    check_eq("sn_hit", sn_hit, se.hit);
                end
            end
            if (ram_w_en) begin
                if (wq.size() == 0) check_eq("write_unexpected", ram_w_en, 0);
                else begin
                    we = wq.pop_front();
                    check_eq("write_cycle", cyc, we.cyc);
                    check_eq("write_addr", ram_addr, we.set);
                    check_eq("write_data", ram_wdata, we.data);
                end
            end
            if (busy > 0) begin
                check_eq("ready_while_busy", rdy, 0);
                if (busy == 1 && pend) begin
                    shadow[pend_set] = pend_data;
                    pend = 0;
                end
                busy--;
            end else begin
                expg = 3'b000;
                if (lk_valid && scnt == LIM) expg = 3'b001;
                else if (fill_valid) expg = 3'b100;
                else if (sn_valid) expg = 3'b010;
                else if (lk_valid) expg = 3'b001;
                check_eq("grant", rdy, expg);
                if (expg == 3'b001) scnt = 0;
                else if (lk_valid && expg != 3'b000 && scnt < LIM) scnt++;
                case (expg)
                    3'b001: begin
                        s = lk_addr[9:6]; t = lk_addr[31:10]; e = shadow[s];
                        h = (e[21:0] == t) && (e[23:22] != 2'b10);
                        lkq.push_back('{cyc + 3, h, e[23:22]});
                        busy = 2;
                    end
                    3'b010: begin
                        s = sn_addr[9:6]; t = sn_addr[31:10]; e = shadow[s];
                        h = (e[21:0] == t) && (e[23:22] != 2'b10);
                        snq.push_back('{cyc + 3, h});
                        if (h) begin
                            wq.push_back('{cyc + 3, s, {2'b10, t}});
                            pend = 1; pend_set = s; pend_data = {2'b10, t};
                            busy = 3;
                        end else busy = 2;
                    end
                    3'b100: begin
                        s = fill_addr[9:6]; t = fill_addr[31:10];
                        wq.push_back('{cyc + 1, s, {2'b01, t}});
                        pend = 1; pend_set = s; pend_data = {2'b01, t};
                        busy = 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] rnd_addr();
        logic [21:0] t;
        logic [3:0] s;
        logic [5:0] o;
        t = 22'($urandom_range(0, 3));
        s = 4'($urandom_range(0, 3));
        o = 6'($urandom_range(0, 63));
        return {t, s, o};
    endfunction

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // which: 0 lookup, 1 snoop, 2 fill
    task automatic req(input int which, input logic [31:0] a);
        bit got;
        got = 0;
        case (which)
            0: begin lk_valid = 1; lk_addr = a; end
            1: begin sn_valid = 1; sn_addr = a; end
            default: begin fill_valid = 1; fill_addr = a; end
        endcase
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = (which == 0) ? lk_ready : (which == 1) ? sn_ready : fill_ready;
        end
        check_eq("accept_timeout", got, 1);
        @(posedge clk); #1;
        case (which)
            0: lk_valid = 0;
            1: sn_valid = 0;
            default: fill_valid = 0;
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gq[$];
        int nf;
        bit got;
        logic [2:0] acc;

        lk_addr = 0; sn_addr = 0; fill_addr = 0;
        lk_valid = 1; sn_valid = 1; fill_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_lk_resp_valid", lk_resp_valid, 0);
        check_eq("rst_lk_hit", lk_hit, 0);
        check_eq("rst_lk_state", lk_state, 2'b10);
        check_eq("rst_sn_resp_valid", sn_resp_valid, 0);
        check_eq("rst_sn_hit", sn_hit, 0);
        check_eq("rst_wdata", ram_wdata, 0);
        check_eq("rst_rw_addr", ram_addr, 0);
        @(posedge clk); #1;
        lk_valid = 0; sn_valid = 0; fill_valid = 0;
        ram_clr = 0; rst = 0;
        settle(2);

        req(0, 32'h0000_1040); settle(4);
        check_eq("tp_cold_lk_hit", lk_hit, 0);
        check_eq("tp_cold_lk_state", lk_state, 2'b10);
        req(2, 32'h0000_1040); settle(3);
        req(0, 32'h0000_1040); settle(4);
        check_eq("tp_fill_lk_hit", lk_hit, 1);
        check_eq("tp_fill_lk_state", lk_state, 2'b01);
        req(0, 32'h0000_2040); settle(4);
        check_eq("tp_other_tag_lk_hit", lk_hit, 0);
        check_eq("tp_other_tag_lk_state", lk_state, 2'b01);
        req(1, 32'h0000_1040); settle(5);
        check_eq("tp_snoop1_hit", sn_hit, 1);
        req(0, 32'h0000_1040); settle(4);
        check_eq("tp_after_snoop_lk_hit", lk_hit, 0);
        check_eq("tp_after_snoop_lk_state", lk_state, 2'b10);
        req(1, 32'h0000_1040); settle(5);
        check_eq("tp_snoop2_hit", sn_hit, 0);

        // all three requesters at once
        lk_valid = 1; lk_addr = 32'h0000_3080;
        sn_valid = 1; sn_addr = 32'h0000_1040;
        fill_valid = 1; fill_addr = 32'h0000_5080;
        for (int n = 0; n < 100 && (lk_valid || sn_valid || fill_valid); n++) begin
            @(negedge clk);
            acc = {fill_valid && fill_ready, sn_valid && sn_ready, lk_valid && lk_ready};
            if (acc[2]) gq.push_back(2);
            if (acc[1]) gq.push_back(1);
            if (acc[0]) gq.push_back(0);
            @(posedge clk); #1;
            if (acc[2]) fill_valid = 0;
            if (acc[1]) sn_valid = 0;
            if (acc[0]) lk_valid = 0;
        end
        lk_valid = 0; sn_valid = 0; fill_valid = 0;
        check_eq("simul_grant_count", gq.size(), 3);
        if (gq.size() == 3) begin
            check_eq("simul_first_fill", gq[0], 2);
            check_eq("simul_second_snoop", gq[1], 1);
            check_eq("simul_third_lookup", gq[2], 0);
        end
        settle(5);

        // starvation, twice to show the counter restarts from zero
        for (int r = 0; r < 2; r++) begin
            lk_valid = 1; lk_addr = 32'h0000_7100;
            fill_valid = 1; fill_addr = 32'h0000_9140;
            nf = 0; got = 0;
            for (int n = 0; n < 100 && !got; n++) begin
                @(negedge clk);
                if (fill_valid && fill_ready) nf++;
                if (lk_ready) got = 1;
                @(posedge clk); #1;
            end
            lk_valid = 0; fill_valid = 0;
            check_eq("starve_lookup_granted", got, 1);
            check_eq("starve_fills_before_lookup", nf, LIM);
            settle(4);
        end

        // reset during SN_CMP of a hitting snoop
        req(2, 32'h0000_1040); settle(3);
        sn_valid = 1; sn_addr = 32'h0000_1040;
        got = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = sn_ready;
        end
        check_eq("rst_snoop_accept", got, 1);
        @(posedge clk); #1;
        sn_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        settle(4);
        check_eq("rst_snoop_sn_hit_cleared", sn_hit, 0);
        req(0, 32'h0000_1040); settle(4);
        check_eq("rst_entry_still_hit", lk_hit, 1);
        check_eq("rst_entry_still_c", lk_state, 2'b01);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            acc = {fill_valid && fill_ready, sn_valid && sn_ready, lk_valid && lk_ready};
            @(posedge clk); #1;
            if (acc[0]) lk_valid = 0;
            if (acc[1]) sn_valid = 0;
            if (acc[2]) fill_valid = 0;
            if (!lk_valid && $urandom_range(0, 2) == 0) begin lk_valid = 1; lk_addr = rnd_addr(); end
            if (!sn_valid && $urandom_range(0, 7) == 0) begin sn_valid = 1; sn_addr = rnd_addr(); end
            if (!fill_valid && $urandom_range(0, 5) == 0) begin fill_valid = 1; fill_addr = rnd_addr(); end
        end
        // let any request still held be accepted before going quiet
        for (int n = 0; n < 50 && (lk_valid || sn_valid || fill_valid); n++) begin
            @(negedge clk);
            acc = {fill_valid && fill_ready, sn_valid && sn_ready, lk_valid && lk_ready};
            @(posedge clk); #1;
            if (acc[0]) lk_valid = 0;
            if (acc[1]) sn_valid = 0;
            if (acc[2]) fill_valid = 0;
        end
        check_eq("drain_requests", {lk_valid, sn_valid, fill_valid}, 0);
        lk_valid = 0; sn_valid = 0; fill_valid = 0;
        settle(10);
        check_eq("lk_queue_empty", lkq.size(), 0);
        check_eq("sn_queue_empty", snq.size(), 0);
        check_eq("wr_queue_empty", wq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_tag_ram_ctrl.md
# instr_tag_ram_ctrl

Sequencing controller for the I-Cache state-tag RAM: a single-port array with one read/write address and one-cycle registered read. It shares that port between three requesters: CPU fetch lookups, coherence snoop-invalidates and line-fill tag writes. Requests are strictly serialized, so no read/write hazard exists on the array. It sits between the I-Cache fetch pipeline, the snoop interface and the refill engine.

## Interface
- SET_WIDTH, 4, set index bits = addr[SET_WIDTH+5:6]
- STATE_WIDTH, 2, state encoding: I=2'b10, C=2'b01, D=2'b00
- TAG_WIDTH, 22, tag = addr[31:32-TAG_WIDTH]; constraint TAG_WIDTH+SET_WIDTH+6 = 32
- STARVE_LIMIT, 4, denied-lookup cycles before lookup gets top priority; legal range 1..15
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- lk_valid / lk_ready  in / out  1  lookup request handshake
- lk_addr  in  32  lookup address
- lk_resp_valid  out  1  one-cycle lookup result strobe
- lk_hit  out  1  tag match and state != I
- lk_state  out  STATE_WIDTH  stored state of the indexed entry
- sn_valid / sn_ready  in / out  1  snoop-invalidate handshake
- sn_addr  in  32  snoop address
- sn_resp_valid  out  1  one-cycle snoop result strobe
- sn_hit  out  1  entry matched and was invalidated
- fill_valid / fill_ready  in / out  1  fill tag-write handshake
- fill_addr  in  32  filled line address
- ram_w_en  out  1  RAM write enable
- ram_w_state_tag  out  STATE_WIDTH+TAG_WIDTH  RAM write data {state, tag}
- ram_rw_addr  out  SET_WIDTH  RAM address
- ram_r_state_tag  in  STATE_WIDTH+TAG_WIDTH  RAM registered read data

## Operation
- FSM states: IDLE, LK_RD, LK_CMP, SN_RD, SN_CMP, SN_WR, FILL_WR.
- Readies are high only in IDLE and only for the single requester granted this cycle. They are combinational from state, valids and starve flag.
- Grant priority: fill > snoop > lookup.
- Exception: when starve_cnt == STARVE_LIMIT and lk_valid is high, lookup wins.
- On accept, the address is latched into an internal register and the FSM leaves IDLE.
- Transitions:
  - IDLE→LK_RD, SN_RD or FILL_WR on the corresponding accept.
  - LK_RD→LK_CMP→IDLE.
  - SN_RD→SN_CMP.
  - SN_CMP→SN_WR if hit, else IDLE.
  - SN_WR→IDLE.
  - FILL_WR→IDLE.
- ram_rw_addr = latched set in every non-IDLE state; 0 in IDLE.
- ram_w_en is high only in SN_WR and FILL_WR:
  - SN_WR writes {2'b10, latched tag}.
  - FILL_WR writes {2'b01, latched tag}.
- Compare (LK_CMP, SN_CMP): hit = (ram_r_state_tag tag field == latched tag) && (state field != 2'b10). D counts as valid.
- Lookup result registers at end of LK_CMP: lk_hit = hit, lk_state = read state field (even on miss).
- Snoop result registers at end of SN_CMP: sn_hit = hit.
- starve_cnt: 4-bit counter.
  - Increments (saturating at STARVE_LIMIT) each IDLE cycle where lk_valid=1 and another requester is granted.
  - Clears on lookup accept.
  - Holds otherwise.
- Requesters must hold valid and address stable until ready; the block never drops an accepted request except on reset.

## Timing
- Accept edge is the end of cycle A.
- Lookup:
  - LK_RD in A+1; ram_r_state_tag valid in A+2 (LK_CMP).
  - lk_resp_valid high for exactly cycle A+3; FSM in IDLE in A+3, so the next accept can occur in A+3.
  - Throughput: 1 lookup per 3 cycles.
- Snoop:
  - sn_resp_valid high in cycle A+3.
  - On hit, SN_WR occupies A+3 (write lands at end of A+3) and IDLE resumes at A+4.
- Fill: ram_w_en high in A+1; IDLE at A+2. There is no response strobe.
- lk_hit, lk_state and sn_hit hold their last value between strobes.
- Reset values: state IDLE, all readies 0 during reset, lk_resp_valid=0, lk_hit=0, lk_state=2'b10, sn_resp_valid=0, sn_hit=0, ram_w_en=0, ram_w_state_tag=0, ram_rw_addr=0, starve_cnt=0.
- Reset mid-operation: the in-flight request is discarded, with no write and no response. Reset asserted during SN_WR or FILL_WR cycle forces ram_w_en=0 in the following cycle; the write in the reset cycle itself is suppressed because ram_w_en is gated by !rst.
- Simultaneous valids in IDLE: only one grant per cycle; losers see ready=0 and must hold.

## Test plan
- After reset (RAM all {10, 0}), lookup 0x0000_1040 (set 1, tag 4) → lk_resp_valid at A+3, lk_hit=0, lk_state=2'b10.
- Fill 0x0000_1040, then lookup same address → ram_w_en at A+1 with ram_rw_addr=1 and data {01, 22'h4}; lookup returns lk_hit=1, lk_state=2'b01. Lookup 0x0000_2040 (same set, tag 8) → lk_hit=0.
- Snoop 0x0000_1040 after the fill → sn_hit=1 at A+3, write {10, 22'h4} in A+3; a subsequent lookup returns lk_hit=0, lk_state=2'b10. A second snoop → sn_hit=0, no write.
- fill_valid, sn_valid and lk_valid raised together in one cycle → grants in order fill, snoop, lookup; exactly one ready per IDLE cycle.
- STARVE_LIMIT=2, lk_valid held high with back-to-back fills → lookup granted on the third IDLE cycle despite a pending fill; starve_cnt returns to 0.
- Assert rst during SN_CMP of a hitting snoop → no sn_resp_valid, ram_w_en stays 0, FSM in IDLE after release, and entry still reads as C.
